trace_monitor: RTL

Synthesizable commit-trace monitor for the WISC CPU family, generalising the phase-1 bench's trace logic to pipelined cores. It sits beside the CPU, samples one retirement event per cycle, classifies it (register write, load, store, other, halt), numbers it, and queues a trace record in a parametrised FIFO for a bench, a debug port or on-chip capture. It also keeps cycle and instruction counters, detects halt-drain completion and flags a cycle-budget timeout.

---
 rtl/trace_pkg.sv | 43 ++++
 rtl/trace_fifo.sv | 73 +++++++
 rtl/trace_monitor.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/trace_pkg.sv
// trace_pkg: shared definitions for the commit-trace monitor.
//   - kind_t   : record classification codes seen on rd_kind
//   - state_t  : monitor run state (RUN, HALTED, TIMEOUT)
//   - classify : maps retirement flags onto a record kind
//   - recWidth : packed record width for a given set of field widths
package trace_pkg;

  localparam int KIND_W = 3;

  typedef enum logic [KIND_W-1:0] {
    KIND_REG   = 3'd0,
    KIND_LOAD  = 3'd1,
    KIND_STORE = 3'd2,
    KIND_OTHER = 3'd3,
    KIND_HALT  = 3'd4
  } kind_t;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_HALTED,
    ST_TIMEOUT
  } state_t;

  // A load also writes a register, so it must be recognised before the plain
  // register-write case; halt outranks a store so a halting instruction is never
  // reported as memory traffic.
  function automatic kind_t classify(input logic regWe, input logic memRd,
                                     input logic memWe, input logic hlt);
    kind_t k;
    if (regWe && memRd)  k = KIND_LOAD;
    else if (regWe)      k = KIND_REG;
    else if (hlt)        k = KIND_HALT;
    else if (memWe)      k = KIND_STORE;
    else                 k = KIND_OTHER;
    return k;
  endfunction

  // Record layout, MSB first: kind, inum, pc, reg, val, addr.
  function automatic int recWidth(input int dataW, input int regW, input int cntW);
    return KIND_W + cntW + 3 * dataW + regW;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: synchronous FIFO with valid/ready handshakes and a tail-overwrite
// request used when a record must not be lost.
//   clk, rst            : clock, synchronous active-high reset (flushes FIFO)
//   pushValid/pushData  : write request; accepted when not full or a pop happens
//   overwrite           : if the push cannot be accepted, replace the newest entry
//   popValid/popReady   : head available / consumer takes head
//   popData             : head entry (registered contents, no fall-through)
//   full, empty         : occupancy flags
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pushValid,
  input  logic [WIDTH-1:0] pushData,
  input  logic             overwrite,
  output logic             popValid,
  input  logic             popReady,
  output logic [WIDTH-1:0] popData,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrIdx;
  logic [AW-1:0]    rdIdx;
  logic [AW-1:0]    tailIdx;
  logic             popFire;
  logic             pushFire;

  // Pointers carry an extra wrap bit so full and empty are distinguishable when
  // the indices coincide. A pop in the same cycle frees a slot for a push even
  // when the FIFO is full.
  always_comb begin
    wrIdx    = wrPtr[AW-1:0];
    rdIdx    = rdPtr[AW-1:0];
    tailIdx  = wrIdx - AW'(1);
    empty    = (wrPtr == rdPtr);
    full     = (wrIdx == rdIdx) && (wrPtr[AW] != rdPtr[AW]);
    popValid = ~empty;
    popData  = mem[rdIdx];
    popFire  = popValid & popReady;
    pushFire = pushValid & (~full | popFire);
  end

  // Pointer updates; reset flushes the FIFO by realigning both pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (pushFire) wrPtr <= wrPtr + 1'b1;
      if (popFire)  rdPtr <= rdPtr + 1'b1;
    end
  end

  // Storage. A rejected push with overwrite set lands on the newest entry; the
  // FIFO is full in that case so the tail is never the head being read.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (pushFire)
        mem[wrIdx] <= pushData;
      else if (pushValid && overwrite && full)
        mem[tailIdx] <= pushData;
    end
  end

endmodule

// File: rtl/trace_monitor.sv
// trace_monitor: classifies one retirement event per cycle, numbers it and
// queues a trace record; keeps cycle/instruction/drop counters and tracks the
// RUN / HALTED / TIMEOUT state.
//   clk, rst      : clock, synchronous active-high reset
//   cm_*          : retirement event from the CPU (valid, pc, flags, reg, data, addr)
//   rd_valid/ready: record handshake; rd_kind/inum/pc/reg/val/addr is the head record
//   cycle_cnt, inst_cnt, drop_cnt : saturating counters
//   overflow, halted, done, timeout : status flags
module trace_monitor
  import trace_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int REG_W   = 4,
  parameter int DEPTH   = 16,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cm_valid,
  input  logic [DATA_W-1:0] cm_pc,
  input  logic              cm_reg_we,
  input  logic              cm_mem_rd,
  input  logic              cm_mem_we,
  input  logic              cm_hlt,
  input  logic [REG_W-1:0]  cm_reg,
  input  logic [DATA_W-1:0] cm_reg_data,
  input  logic [DATA_W-1:0] cm_mem_addr,
  input  logic [DATA_W-1:0] cm_mem_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [2:0]        rd_kind,
  output logic [CNT_W-1:0]  rd_inum,
  output logic [DATA_W-1:0] rd_pc,
  output logic [REG_W-1:0]  rd_reg,
  output logic [DATA_W-1:0] rd_val,
  output logic [DATA_W-1:0] rd_addr,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  inst_cnt,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic              overflow,
  output logic              halted,
  output logic              done,
  output logic              timeout
);

  localparam int REC_W = recWidth(DATA_W, REG_W, CNT_W);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state;
  state_t            stateNext;
  kind_t             eventKind;
  logic              eventAccept;
  logic              isHalt;
  logic              popFire;
  logic              dropEvent;
  logic              fifoFull;
  logic              fifoEmpty;
  logic              headValid;
  logic [REG_W-1:0]  recReg;
  logic [DATA_W-1:0] recVal;
  logic [DATA_W-1:0] recAddr;
  logic [REC_W-1:0]  pushRec;
  logic [REC_W-1:0]  headRec;
  logic [2:0]        headKind;
  logic [CNT_W-1:0]  headInum;
  logic [DATA_W-1:0] headPc;
  logic [REG_W-1:0]  headReg;
  logic [DATA_W-1:0] headVal;
  logic [DATA_W-1:0] headAddr;

  // Classify the presented event and build its record. Fields that carry no
  // meaning for a kind are forced to zero so consumers can compare records
  // without knowing which fields apply.
  always_comb begin
    eventKind   = classify(cm_reg_we, cm_mem_rd, cm_mem_we, cm_hlt);
    eventAccept = cm_valid && (state == ST_RUN);
    isHalt      = (eventKind == KIND_HALT);
    recReg      = '0;
    recVal      = '0;
    recAddr     = '0;
    case (eventKind)
      KIND_REG: begin
        recReg = cm_reg;
        recVal = cm_reg_data;
      end
      KIND_LOAD: begin
        recReg  = cm_reg;
        recVal  = cm_reg_data;
        recAddr = cm_mem_addr;
      end
      KIND_STORE: begin
        recVal  = cm_mem_data;
        recAddr = cm_mem_addr;
      end
      default: ;
    endcase
    pushRec   = {eventKind, inst_cnt, cm_pc, recReg, recVal, recAddr};
    popFire   = headValid & rd_ready;
    dropEvent = eventAccept & fifoFull & ~popFire;
  end

  // Halt records ask the FIFO to overwrite the tail when there is no room, so
  // the halt always reaches the consumer; the displaced record counts as a drop.
  trace_fifo #(
    .WIDTH(REC_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .pushValid(eventAccept),
    .pushData (pushRec),
    .overwrite(isHalt),
    .popValid (headValid),
    .popReady (rd_ready),
    .popData  (headRec),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

  // Head record unpacking; the record fields read as zero while nothing is
  // queued so the outputs are clean straight after reset.
  always_comb begin
    {headKind, headInum, headPc, headReg, headVal, headAddr} = headRec;
    rd_valid = headValid;
    rd_kind  = headValid ? headKind : '0;
    rd_inum  = headValid ? headInum : '0;
    rd_pc    = headValid ? headPc   : '0;
    rd_reg   = headValid ? headReg  : '0;
    rd_val   = headValid ? headVal  : '0;
    rd_addr  = headValid ? headAddr : '0;
    halted   = (state == ST_HALTED);
    timeout  = (state == ST_TIMEOUT);
    done     = halted & fifoEmpty;
  end

  // Next-state logic. A halt in the very cycle the budget runs out still wins,
  // because the program did finish. The timeout fires on the edge that brings
  // cycle_cnt up to TIMEOUT, so the counter freezes exactly at the budget.
  always_comb begin
    stateNext = state;
    case (state)
      ST_RUN: begin
        if (eventAccept && isHalt)
          stateNext = ST_HALTED;
        else if (cycle_cnt == TIMEOUT_LAST)
          stateNext = ST_TIMEOUT;
      end
      default: stateNext = state;
    endcase
  end

  // State register and counters. Counters advance only while running and
  // saturate rather than wrap; every accepted event is numbered even when its
  // record is dropped so gaps in rd_inum reveal the loss.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      cycle_cnt <= '0;
      inst_cnt  <= '0;
      drop_cnt  <= '0;
      overflow  <= 1'b0;
    end else begin
      state <= stateNext;
      if (state == ST_RUN) begin
        if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + 1'b1;
        if (eventAccept && (inst_cnt != '1)) inst_cnt <= inst_cnt + 1'b1;
      end
      if (dropEvent) begin
        if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
        overflow <= 1'b1;
      end
    end
  end

endmodule
